// File: rtl/sl_bus_arbiter.sv
// Round-robin arbiter for the shared slave data bus: grants one requester at a time
// and forwards its bytes one at a time to a valid/ready transmitter.
module sl_bus_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] sl_arb_request,
  output logic [NUM_PORTS-1:0] sl_arb_grant,
  input  logic [7:0]           sl_data,
  output logic                 sl_data_latch,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_first,
  output logic [15:0]          frame_count,
  output logic [7:0]           debug
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_owner;
  logic [2:0]  r_rr_ptr;
  logic [7:0]  r_tx_data;
  logic        r_first;
  logic        r_sent;
  logic [15:0] r_frame_count;

  logic [2:0]  w_next_state;
  logic [7:0]  w_req8;
  logic        w_owner_req;
  logic [2:0]  w_winner;
  logic [2:0]  w_idx;
  logic        w_found;
  logic        w_release;
  logic        w_count;
  logic [2:0]  w_next_ptr;

  assign w_req8      = 8'(sl_arb_request);
  assign w_owner_req = w_req8[r_owner];
  assign w_next_ptr  = (r_owner == LAST_PORT) ? 3'd0 : r_owner + 3'd1;
  assign w_count     = (r_state == S_SEND) && tx_ready && !w_owner_req;
  assign w_release   = w_count || ((r_state == S_GRANT) && !w_owner_req);

  // Round-robin search: first set request at or after rr_ptr, wrapping at NUM_PORTS.
  always_comb begin
    w_idx    = r_rr_ptr;
    w_winner = r_rr_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_req8[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
      w_idx = (w_idx == LAST_PORT) ? 3'd0 : w_idx + 3'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = (|sl_arb_request) ? S_GRANT : S_IDLE;
      S_GRANT: w_next_state = w_owner_req ? S_LATCH : S_IDLE;
      S_LATCH: w_next_state = S_SEND;
      S_SEND: begin
        if (tx_ready) begin
          w_next_state = w_owner_req ? S_LATCH : S_IDLE;
        end else begin
          w_next_state = S_SEND;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Owner, round-robin pointer, byte holding register and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner       <= 3'd0;
      r_rr_ptr      <= 3'd0;
      r_tx_data     <= 8'h00;
      r_first       <= 1'b0;
      r_sent        <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      if ((r_state == S_IDLE) && (|sl_arb_request)) begin
        r_owner <= w_winner;
      end
      if (w_release) begin
        r_rr_ptr <= w_next_ptr;
        r_sent   <= 1'b0;
      end
      // tx_first marks only the byte captured by the first LATCH of a grant.
      if (r_state == S_LATCH) begin
        r_tx_data <= sl_data;
        r_first   <= ~r_sent;
        r_sent    <= 1'b1;
      end
      if (w_count) begin
        r_frame_count <= r_frame_count + 16'h0001;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    sl_arb_grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sl_arb_grant[i] = (r_state != S_IDLE) && (r_owner == 3'(i));
    end
    sl_data_latch = (r_state == S_LATCH);
    tx_valid      = (r_state == S_SEND);
    tx_first      = (r_state == S_SEND) && r_first;
    tx_data       = r_tx_data;
    frame_count   = r_frame_count;
    debug         = {r_state, r_owner, 2'b00};
  end

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Directed bench for sl_bus_arbiter: requester queues drive the bus, a behavioural
// model is compared every cycle, and literal expectations pin the transfer log.
module tb_sl_bus_arbiter;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] gnt;
  logic [7:0]    sl_data = 8'h00;
  logic          latch;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_first;
  logic [15:0]   frame_count;
  logic [7:0]    debug;

  sl_bus_arbiter #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .sl_arb_request(req), .sl_arb_grant(gnt),
    .sl_data(sl_data), .sl_data_latch(latch), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_first(tx_first),
    .frame_count(frame_count), .debug(debug)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  logic [7:0]    fq [NP][$];
  logic [NP-1:0] pulse = '0;

  int          cyc = 0;
  int          m_owner = -1;
  int          m_rr = 0;
  logic [2:0]  m_last_owner = 3'd0;
  bit          m_settle = 1'b0, m_latching = 1'b0, m_holding = 1'b0;
  bit          m_first = 1'b0, m_sent = 1'b0;
  logic [7:0]  m_txd = 8'h00;
  logic [15:0] m_frames = 16'h0000;
  int          m_consumed = -1;

  logic [7:0]    log_data [$];
  bit            log_first [$];
  logic [NP-1:0] log_grant [$];
  int            log_cyc [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: one grant lifecycle expressed as settle/latch/hold flags.
  always @(posedge clk) begin
    int found;
    cyc++;
    m_consumed = -1;
    if (rst) begin
      m_owner = -1; m_rr = 0; m_last_owner = 3'd0;
      m_settle = 0; m_latching = 0; m_holding = 0; m_first = 0; m_sent = 0;
      m_txd = 8'h00; m_frames = 16'h0000;
    end else if (m_owner < 0) begin
      found = -1;
      for (int k = 0; k < NP; k++)
        if (found < 0 && req[(m_rr + k) % NP]) found = (m_rr + k) % NP;
      if (found >= 0) begin
        m_owner = found; m_last_owner = 3'(found); m_settle = 1;
      end
    end else if (m_settle) begin
      m_settle = 0;
      if (req[m_owner]) m_latching = 1;
      else begin m_rr = (m_owner + 1) % NP; m_owner = -1; m_sent = 0; end
    end else if (m_latching) begin
      m_latching = 0; m_holding = 1; m_txd = sl_data;
      m_first = !m_sent; m_sent = 1; m_consumed = m_owner;
    end else if (m_holding && tx_ready) begin
      m_holding = 0;
      if (req[m_owner]) m_latching = 1;
      else begin
        m_rr = (m_owner + 1) % NP; m_owner = -1; m_sent = 0; m_frames = m_frames + 16'h0001;
      end
    end
  end

  // Per-cycle compare against the model, plus capture of every transfer.
  always @(negedge clk) begin
    logic [NP-1:0] eg;
    if (chk_en) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("grant", 32'(gnt), 32'(eg));
      check("sl_data_latch", 32'(latch), 32'(m_latching));
      check("tx_valid", 32'(tx_valid), 32'(m_holding));
      check("tx_data", 32'(tx_data), 32'(m_txd));
      check("tx_first", 32'(tx_first), 32'(m_holding && m_first));
      check("frame_count", 32'(frame_count), 32'(m_frames));
      check("debug_owner", 32'(debug[4:0]), 32'({m_last_owner, 2'b00}));
      if (tx_valid && tx_ready) begin
        log_data.push_back(tx_data); log_first.push_back(tx_first);
        log_grant.push_back(gnt); log_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive();
    for (int p = 0; p < NP; p++) req[p] = (fq[p].size() != 0) || pulse[p];
    if (m_owner >= 0 && fq[m_owner].size() != 0) sl_data = fq[m_owner][0];
    else sl_data = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_consumed >= 0 && fq[m_consumed].size() != 0) void'(fq[m_consumed].pop_front());
    pulse = '0;
    drive();
  endtask

  task automatic clear_log();
    log_data.delete(); log_first.delete(); log_grant.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) fq[p].delete();
    rst = 1'b1; drive();
    tick(); tick();
    rst = 1'b0; drive();
    clear_log();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      busy = (m_owner >= 0) || (pulse != '0);
      for (int p = 0; p < NP; p++) if (fq[p].size() != 0) busy = 1'b1;
      if (busy) begin tick(); n++; end
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
    tick(); tick();
  endtask

  task automatic check_log(input string nm, input int n, input logic [7:0] d [4],
                           input bit f [4], input logic [NP-1:0] g [4]);
    check({nm, "_count"}, 32'(log_data.size()), 32'(n));
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      check({nm, "_data"}, 32'(log_data[i]), 32'(d[i]));
      check({nm, "_first"}, 32'(log_first[i]), 32'(f[i]));
      check({nm, "_grant"}, 32'(log_grant[i]), 32'(g[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]    d [4];
    bit            f [4];
    logic [NP-1:0] g [4];
    int            req_cyc;

    do_reset();
    chk_en = 1'b1;
    check("rst_grant", 32'(gnt), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_latch", 32'(latch), 32'd0);

    // Port 1 three-byte frame, tx_ready high.
    tx_ready = 1'b1;
    fq[1] = '{8'hA5, 8'h01, 8'h7E};
    req_cyc = cyc;
    drive();
    wait_idle(60);
    d = '{8'hA5, 8'h01, 8'h7E, 8'h00}; f = '{1, 0, 0, 0}; g = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    check_log("p1_frame", 3, d, f, g);
    if (log_cyc.size() == 3) begin
      check("p1_latency", 32'(log_cyc[0] - req_cyc), 32'd3);
      check("p1_gap0", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
      check("p1_gap1", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
    end
    check("p1_frames", 32'(frame_count), 32'd1);
    check("p1_grant_low", 32'(gnt), 32'd0);

    // Ports 0 and 2 together: round-robin from pointer 0.
    do_reset();
    fq[0] = '{8'h11}; fq[2] = '{8'h22};
    drive();
    wait_idle(60);
    d = '{8'h11, 8'h22, 8'h00, 8'h00}; f = '{1, 1, 0, 0}; g = '{4'b0001, 4'b0100, 4'b0000, 4'b0000};
    check_log("rr", 2, d, f, g);
    check("rr_frames", 32'(frame_count), 32'd2);

    // Port 3 in progress, port 0 requests meanwhile: no preemption.
    do_reset();
    fq[3] = '{8'h31, 8'h32, 8'h33};
    drive();
    tick(); tick(); tick();
    fq[0] = '{8'h40};
    drive();
    wait_idle(80);
    d = '{8'h31, 8'h32, 8'h33, 8'h40}; f = '{1, 0, 0, 1}; g = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    check_log("nopre", 4, d, f, g);
    check("nopre_frames", 32'(frame_count), 32'd2);

    // Backpressure: tx_ready low for five SEND cycles.
    do_reset();
    tx_ready = 1'b0;
    fq[1] = '{8'h55, 8'h66};
    drive();
    tick(); tick(); tick();
    check("bp_valid", 32'(tx_valid), 32'd1);
    repeat (5) tick();
    check("bp_hold_data", 32'(tx_data), 32'h55);
    tx_ready = 1'b1;
    drive();
    wait_idle(60);
    d = '{8'h55, 8'h66, 8'h00, 8'h00}; f = '{1, 0, 0, 0}; g = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    check_log("bp", 2, d, f, g);
    check("bp_frames", 32'(frame_count), 32'd1);

    // One-cycle request pulse: grant then release, no byte, count unchanged.
    clear_log();
    pulse = 4'b0100;
    drive();
    tick();
    check("pulse_grant", 32'(gnt), 32'b0100);
    wait_idle(20);
    check("pulse_no_bytes", 32'(log_data.size()), 32'd0);
    check("pulse_frames", 32'(frame_count), 32'd1);

    // Reset while a byte is pending in SEND, then a normal frame.
    tx_ready = 1'b0;
    fq[2] = '{8'h77, 8'h88};
    drive();
    tick(); tick(); tick(); tick();
    check("mid_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1; drive();
    tick();
    rst = 1'b0; drive();
    check("mid_rst_grant", 32'(gnt), 32'd0);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_frames", 32'(frame_count), 32'd0);
    check("mid_rst_first", 32'(tx_first), 32'd0);
    clear_log();
    tx_ready = 1'b1;
    drive();
    wait_idle(60);
    d = '{8'h88, 8'h00, 8'h00, 8'h00}; f = '{1, 0, 0, 0}; g = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
    check_log("after_rst", 1, d, f, g);
    check("after_rst_frames", 32'(frame_count), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl_bus_arbiter.md
SL_BUS_ARBITER -- requirements
Module: sl_bus_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, is the number of slave-bus requesters; legal range is 2..8.
REQ-002 clk  input  1  is the clock; all state updates on the rising edge.
REQ-003 rst  input  1  is the reset: synchronous, active-high.
REQ-004 sl_arb_request  input  NUM_PORTS  is one bit per requester, high while that requester holds frame bytes to send.
REQ-005 sl_arb_grant  output  NUM_PORTS  is a one-hot-or-zero grant; the granted requester drives the shared sl_data.
REQ-006 sl_data  input  8  is the shared slave data bus, carrying the granted requester's current byte.
REQ-007 sl_data_latch  output  1  is a one-cycle pulse that consumes the current byte from the granted requester.
REQ-008 tx_data  output  8  is the byte presented to the downstream transmitter.
REQ-009 tx_valid  output  1  is high while tx_data holds an unaccepted byte.
REQ-010 tx_ready  input  1  is the downstream accept; a transfer occurs on any cycle with tx_valid and tx_ready both high.
REQ-011 tx_first  output  1  is high alongside tx_valid when the byte is the first byte of a grant.
REQ-012 frame_count  output  16  is the number of completed grants; it wraps 0xFFFF->0x0000.
REQ-013 debug  output  8  carries {state[2:0], owner[2:0], 2'b00}.

Function
REQ-014 States: IDLE, GRANT, LATCH, SEND; the state register is 3 bits wide.
REQ-015 IDLE: sl_arb_grant=0 and tx_valid=0.
REQ-016 IDLE, any request bit high: the round-robin winner is registered as owner, the FSM goes to GRANT, and sl_arb_grant[owner] is high from the next cycle.
REQ-017 Round-robin search: starts at rr_ptr and ascends modulo NUM_PORTS; the first set request bit wins.
REQ-018 On release, rr_ptr is set to (owner+1) mod NUM_PORTS.
REQ-019 GRANT: lasts one cycle so the bus can settle; sl_data_latch=0.
REQ-020 GRANT exit: if sl_arb_request[owner] is still high, go to LATCH; otherwise release with no byte and no frame_count increment.
REQ-021 LATCH: sl_data_latch=1 for exactly this cycle; tx_data is loaded from sl_data at this edge; next state is SEND.
REQ-022 SEND: tx_valid=1 and tx_data is held stable until the transfer.
REQ-023 SEND, transfer cycle: if sl_arb_request[owner] is high, go to LATCH; otherwise release.
REQ-024 SEND, no transfer: remain in SEND.
REQ-025 Release: go to IDLE, drive grant low on the following cycle, and increment frame_count if at least one byte was sent.
REQ-026 Throughput: with tx_ready tied high, one byte is delivered every 2 cycles.
REQ-027 Initial latency: the first tx_valid occurs 3 cycles after a request is sampled in IDLE.
REQ-028 tx_first is set on the byte loaded in the first LATCH of a grant and cleared on the next LATCH.
REQ-029 sl_data_latch is never high unless sl_arb_grant is nonzero.
REQ-030 sl_arb_grant never changes while tx_valid=1.
REQ-031 A request that drops during SEND does not abort the byte; the byte is delivered, then the grant is released.
REQ-032 Requests from non-owners are ignored until the FSM returns to IDLE; there is no preemption.
REQ-033 A request that rises in the same cycle the owner releases is arbitrated in the next IDLE cycle; IDLE always lasts at least one cycle.
REQ-034 tx_ready high outside SEND has no effect.

Reset
REQ-035 With rst high at an edge: state=IDLE, sl_arb_grant=0, sl_data_latch=0, tx_valid=0, tx_data=0x00, tx_first=0, frame_count=0, rr_ptr=0, owner=0.
REQ-036 Reset mid-frame aborts immediately; any pending byte is discarded and the grant drops on the following cycle.
REQ-037 rst has priority over every other update.

Verification
REQ-038 Port 1 requests a 3-byte frame {0xA5,0x01,0x7E}, tx_ready=1 -> three transfers in that order, 2 cycles apart, tx_first only on 0xA5, frame_count=1, grant[1] low after the last transfer.
REQ-039 Ports 0 and 2 request simultaneously after reset, 1 byte each -> port 0 served first, then port 2; frame_count=2.
REQ-040 Port 3 frame in progress while port 0 requests -> no change to grant[3] until port 3 releases; port 0 is granted next.
REQ-041 tx_ready low for 5 cycles during SEND -> tx_valid and tx_data stable, no extra sl_data_latch pulse, no bytes lost or duplicated.
REQ-042 Request pulses for one cycle only -> GRANT then release, no sl_data_latch, frame_count unchanged.
REQ-043 rst asserted in SEND with tx_valid=1 -> next cycle all outputs at reset values; a subsequent frame is delivered normally.
